ccd_pixel_capture: RTL and testbench

//   Front-end capture stage for the camera pixel path. Samples raw sensor data with

---
 rtl/ccd_pixel_capture.sv | 150 +++++++++++++++
 tb/tb_ccd_pixel_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_capture.sv
// Camera front-end capture: registers raw sensor strobes, gates capture on whole
// frames under start/stop control and tags each valid pixel with its column/row.
module ccd_pixel_capture #(
  parameter int COLS = 1280,
  parameter int ROWS = 960
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY,
  output logic        oLINE_ERR
);

  localparam logic [10:0] X_LAST = 11'(COLS - 1);
  localparam logic [10:0] Y_LAST = 11'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t      state;
  logic        stop_pend;
  logic [11:0] data_d;
  logic        fval_d, lval_d, fval_q, lval_q;
  logic [10:0] x_cnt, y_cnt;
  logic [10:0] x_cur, y_cur;
  logic        frame_start, frame_end, lval_fall;
  logic        cap_now, pix;

  function automatic logic [10:0] wrap_inc(input logic [10:0] v, input logic [10:0] last);
    return (v == last) ? 11'd0 : v + 11'd1;
  endfunction

  // Stage 1: input registers and edge history
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_d <= '0;
      fval_d <= 1'b0;
      lval_d <= 1'b0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
    end else begin
      data_d <= iDATA;
      fval_d <= iFVAL;
      lval_d <= iLVAL;
      fval_q <= fval_d;
      lval_q <= lval_d;
    end
  end

  assign frame_start = fval_d & ~fval_q;
  assign frame_end   = ~fval_d & fval_q;
  assign lval_fall   = ~lval_d & lval_q;

  // The ARMED->CAPTURE transition cycle already captures its pixel.
  assign cap_now = (state == CAPTURE) || (state == ARMED && frame_start && !iEND);
  assign pix     = cap_now & fval_d & lval_d;

  always_comb begin
    x_cur = frame_start ? 11'd0 : x_cnt;
    y_cur = frame_start ? 11'd0 : y_cnt;
  end

  // Control FSM, busy flag and completed-frame counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      stop_pend   <= 1'b0;
      oBUSY       <= 1'b0;
      oFrame_Cont <= '0;
    end else begin
      if (state == CAPTURE && frame_end)
        oFrame_Cont <= oFrame_Cont + 32'd1;
      case (state)
        IDLE: begin
          if (iSTART && !iEND) begin
            state <= ARMED;
            oBUSY <= 1'b1;
          end
        end
        ARMED: begin
          if (iEND) begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end else if (frame_start) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (frame_end && (stop_pend || iEND)) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            oBUSY     <= 1'b0;
          end else if (iEND) begin
            stop_pend <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
          oBUSY     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: pixel outputs and position counters
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDATA     <= '0;
      oDVAL     <= 1'b0;
      oX_Cont   <= '0;
      oY_Cont   <= '0;
      oLINE_ERR <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      oDVAL     <= pix;
      oLINE_ERR <= 1'b0;
      if (pix) begin
        oDATA   <= data_d;
        oX_Cont <= x_cur;
        oY_Cont <= y_cur;
        if (x_cur == X_LAST) begin
          x_cnt <= 11'd0;
          y_cnt <= wrap_inc(y_cur, Y_LAST);
        end else begin
          x_cnt <= x_cur + 11'd1;
          y_cnt <= y_cur;
        end
      end else if (cap_now && lval_fall && x_cur != 11'd0) begin
        // Short line: realign to the start of the next row.
        x_cnt     <= 11'd0;
        y_cnt     <= wrap_inc(y_cur, Y_LAST);
        oLINE_ERR <= 1'b1;
      end else begin
        x_cnt <= x_cur;
        y_cnt <= y_cur;
      end
    end
  end

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture on a 4x3 frame geometry.
module tb_ccd_pixel_capture;
  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [11:0] iDATA = '0;
  logic        iFVAL = 1'b0, iLVAL = 1'b0, iSTART = 1'b0, iEND = 1'b0;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oBUSY, oLINE_ERR;

  ccd_pixel_capture #(.COLS(COLS), .ROWS(ROWS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oBUSY(oBUSY), .oLINE_ERR(oLINE_ERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [11:0] d;
    logic [10:0] x;
    logic [10:0] y;
  } pix_t;

  pix_t q[$];
  int   cyc = 0;
  int   n_err_pulse = 0;
  int   first_drv = -1;
  int   first_out = -1;
  int   checks = 0;
  int   failures = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (oDVAL) begin
      q.push_back('{d: oDATA, x: oX_Cont, y: oY_Cont});
      if (first_out < 0) first_out = cyc;
    end
    if (oLINE_ERR) n_err_pulse++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic f, input logic l, input logic s, input logic e,
                      input logic [11:0] d);
    @(posedge iCLK);
    #1;
    iFVAL = f; iLVAL = l; iSTART = s; iEND = e; iDATA = d;
    if (f && l && first_drv < 0) first_drv = cyc;
  endtask

  // Each row: one blank cycle (carrying start/end pulses if requested) then pixels.
  task automatic send_frame(input int start_row, input int end_row, input int short_row,
                            input logic [11:0] base);
    for (int r = 0; r < ROWS; r++) begin
      tick(1'b1, 1'b0, r == start_row, r == end_row, 12'h000);
      for (int c = 0; c < ((r == short_row) ? 2 : COLS); c++)
        tick(1'b1, 1'b1, 1'b0, 1'b0, base + 12'(r * 16 + c));
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic check_frame(input string tag, input int short_row, input logic [11:0] base);
    int idx = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ((r == short_row) ? 2 : COLS); c++) begin
        if (idx < q.size()) begin
          check_val({tag, "_data"}, 64'(q[idx].d), 64'(base + 12'(r * 16 + c)));
          check_val({tag, "_x"}, 64'(q[idx].x), 64'(c));
          check_val({tag, "_y"}, 64'(q[idx].y), 64'(r));
        end
        idx++;
      end
    end
    check_val({tag, "_count"}, 64'(q.size()), 64'(idx));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dval"}, 64'(oDVAL), 64'd0);
    check_val({tag, "_data"}, 64'(oDATA), 64'd0);
    check_val({tag, "_x"}, 64'(oX_Cont), 64'd0);
    check_val({tag, "_y"}, 64'(oY_Cont), 64'd0);
    check_val({tag, "_frames"}, 64'(oFrame_Cont), 64'd0);
    check_val({tag, "_busy"}, 64'(oBUSY), 64'd0);
    check_val({tag, "_lerr"}, 64'(oLINE_ERR), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("rst");
    iRST = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Test 1: start then two full frames
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("t1_busy_armed", 64'(oBUSY), 64'd1);
    q.delete();
    first_drv = -1;
    first_out = -1;
    send_frame(-1, -1, -1, 12'h100);
    check_frame("t1_f1", -1, 12'h100);
    check_val("t1_latency", 64'(first_out - first_drv), 64'd2);
    q.delete();
    send_frame(-1, -1, -1, 12'h200);
    check_frame("t1_f2", -1, 12'h200);
    check_val("t1_frames", 64'(oFrame_Cont), 64'd2);
    check_val("t1_lerr_none", 64'(n_err_pulse), 64'd0);

    // Test 3: stop requested during row 1; frame completes, then nothing
    check_val("t3_busy_before", 64'(oBUSY), 64'd1);
    q.delete();
    send_frame(-1, 1, -1, 12'h300);
    check_frame("t3_last", -1, 12'h300);
    check_val("t3_frames", 64'(oFrame_Cont), 64'd3);
    check_val("t3_busy_after", 64'(oBUSY), 64'd0);
    q.delete();
    send_frame(-1, -1, -1, 12'h400);
    check_val("t3_no_out", 64'(q.size()), 64'd0);

    // Test 2: start mid-frame; partial frame dropped, next frame captured from 0,0
    q.delete();
    send_frame(1, -1, -1, 12'h500);
    check_val("t2_partial", 64'(q.size()), 64'd0);
    check_val("t2_busy_armed", 64'(oBUSY), 64'd1);
    check_val("t2_frames_hold", 64'(oFrame_Cont), 64'd3);
    send_frame(-1, 1, -1, 12'h600);
    check_frame("t2_next", -1, 12'h600);
    check_val("t2_frames", 64'(oFrame_Cont), 64'd4);

    // Test 4: start+end together from IDLE, then end while ARMED
    tick(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("t4_same_busy", 64'(oBUSY), 64'd0);
    q.delete();
    send_frame(-1, -1, -1, 12'h700);
    check_val("t4_same_no_out", 64'(q.size()), 64'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("t4_armed_busy", 64'(oBUSY), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("t4_end_busy", 64'(oBUSY), 64'd0);
    send_frame(-1, -1, -1, 12'h780);
    check_val("t4_end_no_out", 64'(q.size()), 64'd0);
    check_val("t4_frames", 64'(oFrame_Cont), 64'd4);

    // Test 5: row 1 only 2 pixels long
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    q.delete();
    n_err_pulse = 0;
    send_frame(-1, 2, 1, 12'h800);
    check_frame("t5_short", 1, 12'h800);
    check_val("t5_lerr_pulses", 64'(n_err_pulse), 64'd1);
    check_val("t5_frames", 64'(oFrame_Cont), 64'd5);

    // Test 6: reset mid-line, then no capture without a new start
    tick(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h901);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h902);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h903);
    check_val("t6_dval_before", 64'(oDVAL), 64'd1);
    iRST = 1'b1;
    #1;
    check_all_zero("t6_in_rst");
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    q.delete();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 12'h904);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    send_frame(-1, -1, -1, 12'hA00);
    check_val("t6_no_out", 64'(q.size()), 64'd0);
    check_val("t6_busy", 64'(oBUSY), 64'd0);
    check_val("t6_frames", 64'(oFrame_Cont), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
